// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: groups the decode/execute observation signals and the
// stop/flush controls exchanged between the pipeline and the hazard controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if;
    // ID-stage operand information
    logic [4:0] id_rs1_i;
    logic [4:0] id_rs2_i;
    logic       id_rs1_used_i;
    logic       id_rs2_used_i;
    logic       id_valid_i;
    // EX-stage instruction information
    logic       ex_mem_read_i;
    logic [4:0] ex_wR_i;
    logic [1:0] ex_pc_sel_i;
    logic       ex_discard_i;
    // Pipeline controls
    logic       pc_stop_o;
    logic       if_id_stop_o;
    logic       id_ex_stop_o;
    logic       if_id_flush_o;
    logic       id_flush_o;
    logic       busy_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_valid_i,
        output ex_mem_read_i, ex_wR_i, ex_pc_sel_i, ex_discard_i,
        input  pc_stop_o, if_id_stop_o, id_ex_stop_o, if_id_flush_o, id_flush_o, busy_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs1_used_i, id_rs2_used_i, id_valid_i,
        input  ex_mem_read_i, ex_wR_i, ex_pc_sel_i, ex_discard_i,
        output pc_stop_o, if_id_stop_o, id_ex_stop_o, if_id_flush_o, id_flush_o, busy_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and redirect flush sequencer for the 5-stage core.
// A load in EX whose destination is read by the valid ID instruction holds
// PC and IF/ID and bubbles ID/EX for LOAD_STALL cycles. A taken redirect
// resolved in EX discards the wrong-path IF/ID and ID instructions, keeping
// the IF/ID discard asserted for FLUSH_CYCLES cycles. Redirects always win.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating 32-bit counters of
// stall cycles (stall_cnt_o) and flush cycles (flush_cnt_o).
module hazard_ctrl #(
    parameter int unsigned LOAD_STALL   = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]  stall_cnt_o,
    output logic [31:0]  flush_cnt_o
`endif
);

    // Out-of-range configurations are rejected at elaboration.
    if ((LOAD_STALL < 1) || (LOAD_STALL > 7)) begin : g_bad_load_stall
        $error("hazard_ctrl: LOAD_STALL must be in 1..7");
    end
    if ((FLUSH_CYCLES < 1) || (FLUSH_CYCLES > 3)) begin : g_bad_flush_cycles
        $error("hazard_ctrl: FLUSH_CYCLES must be in 1..3");
    end

    // Counter value loaded on entry: the entry cycle itself is the first
    // stall/flush cycle, so the counters track the remaining ones.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         STALL_MULTI  = (LOAD_STALL > 1);
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;

    logic rs1_match;
    logic rs2_match;
    logic hazard;
    logic redirect;

    logic stop;
    logic flush_ifid;
    logic flush_id;

    // Hazard and redirect detection on the current ID/EX contents.
    always_comb begin
        rs1_match = bus.id_rs1_used_i && (bus.id_rs1_i == bus.ex_wR_i);
        rs2_match = bus.id_rs2_used_i && (bus.id_rs2_i == bus.ex_wR_i);
        // x0 is never written, and a discarded (wrong-path) load never stalls.
        hazard    = bus.ex_mem_read_i && !bus.ex_discard_i && bus.id_valid_i &&
                    (bus.ex_wR_i != 5'd0) && (rs1_match || rs2_match);
        redirect  = (bus.ex_pc_sel_i != 2'b00) && !bus.ex_discard_i;
    end

    // Next-state and control outputs; redirect takes priority everywhere.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stop        = 1'b0;
        flush_ifid  = 1'b0;
        flush_id    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    flush_ifid = 1'b1;
                    flush_id   = 1'b1;
                    if (FLUSH_MULTI) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end
                end else if (hazard) begin
                    stop = 1'b1;
                    if (STALL_MULTI) begin
                        state_d     = ST_STALL;
                        stall_cnt_d = STALL_RELOAD;
                    end
                end
            end

            ST_STALL: begin
                if (redirect) begin
                    // The stalled ID instruction is wrong-path: abandon the stall.
                    flush_ifid  = 1'b1;
                    flush_id    = 1'b1;
                    stall_cnt_d = 3'd0;
                    if (FLUSH_MULTI) begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = FLUSH_RELOAD;
                    end else begin
                        state_d     = ST_RUN;
                    end
                end else begin
                    stop = 1'b1;
                    if (stall_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        stall_cnt_d = 3'd0;
                    end else begin
                        stall_cnt_d = stall_cnt_q - 3'd1;
                    end
                end
            end

            ST_FLUSH: begin
                // Hazards are ignored here: ID holds a wrong-path instruction.
                flush_ifid = 1'b1;
                if (redirect) begin
                    flush_id    = 1'b1;
                    flush_cnt_d = FLUSH_RELOAD;
                end else if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = 3'd0;
                end else begin
                    flush_cnt_d = flush_cnt_q - 3'd1;
                end
            end

            default: begin
                state_d     = ST_RUN;
                stall_cnt_d = 3'd0;
                flush_cnt_d = 3'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= 3'd0;
            flush_cnt_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // The detection path is combinational from the inputs, so the controls are
    // also qualified by rst_n to keep them quiet for the whole reset window.
    assign bus.pc_stop_o     = stop & rst_n;
    assign bus.if_id_stop_o  = stop & rst_n;
    assign bus.id_ex_stop_o  = stop & rst_n;
    assign bus.if_id_flush_o = flush_ifid & rst_n;
    assign bus.id_flush_o    = flush_id & rst_n;
    assign bus.busy_o        = (state_q != ST_RUN);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hffff_ffff) ? v : (v + 32'd1);
    endfunction

    // Saturating counts of stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stop) begin
                perf_stall_q <= sat_inc(perf_stall_q);
            end
            if (flush_ifid) begin
                perf_flush_q <= sat_inc(perf_flush_q);
            end
        end
    end

    assign stall_cnt_o = perf_stall_q;
    assign flush_cnt_o = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: three hazard_ctrl instances (LOAD_STALL/FLUSH_CYCLES of
// 1/1, 3/2 and 4/3) share one stimulus. Directed scenarios use literal
// expectations; the random phase uses a remaining-cycles reference model.
// Output vectors are {pc_stop, if_id_stop, id_ex_stop, if_id_flush, id_flush, busy}.
module tb_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, wr;
    logic       u1, u2, idv, mr, disc;
    logic [1:0] psel;

    logic [5:0] obs [3];
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] ps_obs [3];
    logic [31:0] pf_obs [3];
`endif

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LS = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        localparam int FC = (g == 0) ? 1 : ((g == 1) ? 2 : 3);
        hazard_ctrl_if bus ();
        assign bus.id_rs1_i      = rs1;
        assign bus.id_rs2_i      = rs2;
        assign bus.id_rs1_used_i = u1;
        assign bus.id_rs2_used_i = u2;
        assign bus.id_valid_i    = idv;
        assign bus.ex_mem_read_i = mr;
        assign bus.ex_wR_i       = wr;
        assign bus.ex_pc_sel_i   = psel;
        assign bus.ex_discard_i  = disc;
        hazard_ctrl #(.LOAD_STALL(LS), .FLUSH_CYCLES(FC)) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .bus(bus)
`ifdef HAZARD_PERF_CNT_EN
            ,
            .stall_cnt_o(ps_obs[g]),
            .flush_cnt_o(pf_obs[g])
`endif
        );
        assign obs[g] = {bus.pc_stop_o, bus.if_id_stop_o, bus.id_ex_stop_o,
                         bus.if_id_flush_o, bus.id_flush_o, bus.busy_o};
    end

    // ---------------- reference model ----------------
    int         stall_left [3];
    int         flush_left [3];
    int         nstall [3];
    int         nflush [3];
    int         perf_s_exp [3];
    int         perf_f_exp [3];
    logic [5:0] exp_o [3];

    function automatic int cfg_ls(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int cfg_fc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 3);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            stall_left[k] = 0; flush_left[k] = 0;
            nstall[k] = 0; nflush[k] = 0;
            perf_s_exp[k] = 0; perf_f_exp[k] = 0;
            exp_o[k] = 6'b0;
        end
    endtask

    task automatic model_comb();
        logic hz, red;
        red = (psel != 2'b00) && !disc;
        hz  = mr && !disc && idv && (wr != 5'd0) &&
              ((u1 && (rs1 == wr)) || (u2 && (rs2 == wr)));
        for (int k = 0; k < 3; k++) begin
            nstall[k] = stall_left[k];
            nflush[k] = flush_left[k];
            if (!rst_n) begin
                exp_o[k] = 6'b0; nstall[k] = 0; nflush[k] = 0;
            end else if (stall_left[k] > 0) begin
                if (red) begin
                    exp_o[k] = 6'b000111; nstall[k] = 0; nflush[k] = cfg_fc(k) - 1;
                end else begin
                    exp_o[k] = 6'b111001; nstall[k] = stall_left[k] - 1;
                end
            end else if (flush_left[k] > 0) begin
                if (red) begin
                    exp_o[k] = 6'b000111; nflush[k] = cfg_fc(k) - 1;
                end else begin
                    exp_o[k] = 6'b000101; nflush[k] = flush_left[k] - 1;
                end
            end else if (red) begin
                exp_o[k] = 6'b000110; nflush[k] = cfg_fc(k) - 1;
            end else if (hz) begin
                exp_o[k] = 6'b111000; nstall[k] = cfg_ls(k) - 1;
            end else begin
                exp_o[k] = 6'b000000;
            end
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 3; k++) begin
            stall_left[k] = nstall[k];
            flush_left[k] = nflush[k];
            if (exp_o[k][3]) perf_s_exp[k]++;
            if (exp_o[k][2]) perf_f_exp[k]++;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic set_idle();
        rs1 = 5'd0; rs2 = 5'd0; wr = 5'd0; u1 = 1'b0; u2 = 1'b0;
        idv = 1'b1; mr = 1'b0; disc = 1'b0; psel = 2'b00;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        mr = 1'b1; wr = 5'd5; rs1 = 5'd5; u1 = 1'b1;
        model_reset();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got %b want %b", k, obs[k], 6'b0);
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (ps_obs[k] !== 32'd0 || pf_obs[k] !== 32'd0) begin
                errors++;
                $display("FAIL reset_perf dut%0d got %0d/%0d want 0/0", k, ps_obs[k], pf_obs[k]);
            end
`endif
        end
        #2 rst_n = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        logic [17:0] tab [5];
        tab[0] = {6'b111000, 6'b111000, 6'b111000};
        tab[1] = {6'b111001, 6'b111001, 6'b000000};
        tab[2] = {6'b111001, 6'b111001, 6'b000000};
        tab[3] = {6'b111001, 6'b000000, 6'b000000};
        tab[4] = {6'b000000, 6'b000000, 6'b000000};
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 5; c++) begin
                set_idle();
                if (c == 0) begin
                    mr = 1'b1;
                    if (s == 0) begin wr = 5'd5; rs1 = 5'd5; u1 = 1'b1; rs2 = 5'd6; u2 = 1'b1; end
                    else        begin wr = 5'd7; rs2 = 5'd7; u2 = 1'b1; rs1 = 5'd3; u1 = 1'b1; end
                end
                model_comb();
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (obs[k] !== tab[c][k*6 +: 6]) begin
                        errors++;
                        $display("FAIL load_use s%0d dut%0d cyc%0d got %b want %b",
                                 s, k, c, obs[k], tab[c][k*6 +: 6]);
                    end
                end
                next_cycle();
            end
`ifdef HAZARD_PERF_CNT_EN
            if (s == 0) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (ps_obs[k] !== 32'(cfg_ls(k)) || pf_obs[k] !== 32'd0) begin
                        errors++;
                        $display("FAIL perf_after_stall dut%0d got %0d/%0d want %0d/0",
                                 k, ps_obs[k], pf_obs[k], cfg_ls(k));
                    end
                end
            end
`endif
        end
    endtask

    task automatic test_no_hazard();
        for (int c = 0; c < 6; c++) begin
            set_idle();
            mr = 1'b1; wr = 5'd5; rs1 = 5'd5; u1 = 1'b1;
            case (c)
                0: begin wr = 5'd0; rs1 = 5'd0; rs2 = 5'd0; u2 = 1'b1; end
                1: disc = 1'b1;
                2: begin u1 = 1'b0; rs2 = 5'd5; end
                3: idv = 1'b0;
                4: mr = 1'b0;
                default: begin disc = 1'b1; psel = 2'b01; end
            endcase
            model_comb();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== 6'b0) begin
                    errors++;
                    $display("FAIL no_hazard case%0d dut%0d got %b want %b", c, k, obs[k], 6'b0);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_redirect_priority();
        logic [17:0] tab [4];
        tab[0] = {6'b000110, 6'b000110, 6'b000110};
        tab[1] = {6'b000101, 6'b000101, 6'b111000};
        tab[2] = {6'b000101, 6'b000000, 6'b000000};
        tab[3] = {6'b000000, 6'b000000, 6'b000000};
        for (int c = 0; c < 4; c++) begin
            set_idle();
            if (c <= 1) begin mr = 1'b1; wr = 5'd9; rs1 = 5'd9; u1 = 1'b1; end
            if (c == 0) psel = 2'b01;
            model_comb();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== tab[c][k*6 +: 6]) begin
                    errors++;
                    $display("FAIL redirect_priority dut%0d cyc%0d got %b want %b",
                             k, c, obs[k], tab[c][k*6 +: 6]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_flush_reload();
        logic [17:0] tab [5];
        tab[0] = {6'b000110, 6'b000110, 6'b000110};
        tab[1] = {6'b000111, 6'b000111, 6'b000110};
        tab[2] = {6'b000101, 6'b000101, 6'b000000};
        tab[3] = {6'b000101, 6'b000000, 6'b000000};
        tab[4] = {6'b000000, 6'b000000, 6'b000000};
        for (int c = 0; c < 5; c++) begin
            set_idle();
            if (c == 0) psel = 2'b11;
            if (c == 1) psel = 2'b10;
            model_comb();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== tab[c][k*6 +: 6]) begin
                    errors++;
                    $display("FAIL flush_reload dut%0d cyc%0d got %b want %b",
                             k, c, obs[k], tab[c][k*6 +: 6]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall_abort();
        logic [17:0] tab [5];
        tab[0] = {6'b111000, 6'b111000, 6'b111000};
        tab[1] = {6'b000111, 6'b000111, 6'b000110};
        tab[2] = {6'b000101, 6'b000101, 6'b000000};
        tab[3] = {6'b000101, 6'b000000, 6'b000000};
        tab[4] = {6'b000000, 6'b000000, 6'b000000};
        for (int c = 0; c < 5; c++) begin
            set_idle();
            if (c == 0) begin mr = 1'b1; wr = 5'd12; rs2 = 5'd12; u2 = 1'b1; end
            if (c == 1) psel = 2'b10;
            model_comb();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== tab[c][k*6 +: 6]) begin
                    errors++;
                    $display("FAIL stall_abort dut%0d cyc%0d got %b want %b",
                             k, c, obs[k], tab[c][k*6 +: 6]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_async_reset();
        set_idle();
        mr = 1'b1; wr = 5'd7; rs2 = 5'd7; u2 = 1'b1;
        model_comb();
        next_cycle();
        model_comb();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== ((k == 0) ? 6'b111000 : 6'b111001)) begin
                errors++;
                $display("FAIL pre_reset_stall dut%0d got %b want %b", k, obs[k],
                         (k == 0) ? 6'b111000 : 6'b111001);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d got %b want %b", k, obs[k], 6'b0);
            end
`ifdef HAZARD_PERF_CNT_EN
            checks++;
            if (ps_obs[k] !== 32'd0 || pf_obs[k] !== 32'd0) begin
                errors++;
                $display("FAIL async_reset_perf dut%0d got %0d/%0d want 0/0", k, ps_obs[k], pf_obs[k]);
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 6'b0) begin
                errors++;
                $display("FAIL reset_held dut%0d got %b want %b", k, obs[k], 6'b0);
            end
        end
        #2 rst_n = 1'b1;
        set_idle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            wr   = 5'($urandom_range(0, 3));
            u1   = 1'($urandom_range(0, 1));
            u2   = 1'($urandom_range(0, 1));
            idv  = ($urandom_range(0, 7) != 0);
            mr   = 1'($urandom_range(0, 1));
            disc = ($urandom_range(0, 5) == 0);
            psel = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            model_comb();
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== exp_o[k]) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d got %b want %b", k, c, obs[k], exp_o[k]);
                end
`ifdef HAZARD_PERF_CNT_EN
                checks++;
                if (ps_obs[k] !== 32'(perf_s_exp[k]) || pf_obs[k] !== 32'(perf_f_exp[k])) begin
                    errors++;
                    $display("FAIL random_perf dut%0d cyc%0d got %0d/%0d want %0d/%0d",
                             k, c, ps_obs[k], pf_obs[k], perf_s_exp[k], perf_f_exp[k]);
                end
`endif
            end
            next_cycle();
        end
    endtask

    initial begin
        set_idle();
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_redirect_priority();
        test_flush_reload();
        test_stall_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
